// File: rtl/gpio_port_ctrl.sv
// ============================================================================
//  Module      : gpio_port_ctrl
//  Description : Memory-mapped GPIO register block (DDR / PORT / PIN / SET /
//                CLR / PCMSK / PCIF) with a req/ready bus, a port-latch write
//                strobe, an input synchroniser and a masked pin-change irq.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module gpio_port_ctrl #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] PORT_RESET  = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       bus_req,
    input  logic       bus_we,
    input  logic [2:0] bus_addr,
    input  logic [7:0] bus_wdata,
    output logic       bus_ready,
    output logic [7:0] bus_rdata,
    output logic       port_write_en,
    output logic [7:0] port_data,
    output logic [7:0] ddr,
    input  logic [7:0] pin_in,
    output logic       irq
);

    localparam logic [2:0] c_ADDR_DDR   = 3'd0;
    localparam logic [2:0] c_ADDR_PORT  = 3'd1;
    localparam logic [2:0] c_ADDR_PIN   = 3'd2;
    localparam logic [2:0] c_ADDR_SET   = 3'd3;
    localparam logic [2:0] c_ADDR_CLR   = 3'd4;
    localparam logic [2:0] c_ADDR_PCMSK = 3'd5;
    localparam logic [2:0] c_ADDR_PCIF  = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t                        r_state;
    logic [SYNC_STAGES-1:0][7:0]   r_sync;
    logic [7:0]                    r_prev;
    logic [7:0]                    r_ddr;
    logic [7:0]                    r_port;
    logic [7:0]                    r_pcmsk;
    logic [7:0]                    r_pcif;
    logic                          r_ready;
    logic                          r_wen;
    logic [7:0]                    r_rdata;

    logic                          w_accept;
    logic [7:0]                    w_pin_s;
    logic [7:0]                    w_chg;
    logic [7:0]                    w_w1c;
    logic [7:0]                    w_ddr_next;
    logic [7:0]                    w_port_next;
    logic [7:0]                    w_pcmsk_next;
    logic [7:0]                    w_pcif_next;
    logic [7:0]                    w_rdata;
    logic                          w_port_store;

    // Requests are only looked at in IDLE; RESP ignores bus_req entirely.
    assign w_accept = (r_state == ST_IDLE) && bus_req;
    assign w_pin_s  = r_sync[SYNC_STAGES-1];
    assign w_chg    = (w_pin_s ^ r_prev) & r_pcmsk;

    always_comb begin
        w_ddr_next   = r_ddr;
        w_port_next  = r_port;
        w_pcmsk_next = r_pcmsk;
        w_w1c        = 8'h00;
        w_rdata      = 8'h00;
        w_port_store = 1'b0;
        if (w_accept) begin
            if (bus_we) begin
                case (bus_addr)
                    c_ADDR_DDR:   w_ddr_next = bus_wdata;
                    c_ADDR_PORT: begin
                        w_port_next  = bus_wdata;
                        w_port_store = 1'b1;
                    end
                    c_ADDR_PIN: begin
                        w_port_next  = r_port ^ bus_wdata;
                        w_port_store = 1'b1;
                    end
                    c_ADDR_SET: begin
                        w_port_next  = r_port | bus_wdata;
                        w_port_store = 1'b1;
                    end
                    c_ADDR_CLR: begin
                        w_port_next  = r_port & ~bus_wdata;
                        w_port_store = 1'b1;
                    end
                    c_ADDR_PCMSK: w_pcmsk_next = bus_wdata;
                    c_ADDR_PCIF:  w_w1c        = bus_wdata;
                    default:      w_w1c        = 8'h00;
                endcase
            end else begin
                case (bus_addr)
                    c_ADDR_DDR:   w_rdata = r_ddr;
                    c_ADDR_PORT:  w_rdata = r_port;
                    c_ADDR_PIN:   w_rdata = w_pin_s;
                    c_ADDR_PCMSK: w_rdata = r_pcmsk;
                    c_ADDR_PCIF:  w_rdata = r_pcif;
                    default:      w_rdata = 8'h00;
                endcase
            end
        end
    end

    // A fresh change on a bit overrides a simultaneous write-1-to-clear.
    assign w_pcif_next = (r_pcif & ~w_w1c) | w_chg;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sync  <= '0;
            r_prev  <= 8'h00;
            r_ddr   <= 8'h00;
            r_port  <= PORT_RESET;
            r_pcmsk <= 8'h00;
            r_pcif  <= 8'h00;
            r_ready <= 1'b0;
            r_wen   <= 1'b0;
            r_rdata <= 8'h00;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], pin_in};
            r_prev  <= w_pin_s;
            r_ddr   <= w_ddr_next;
            r_port  <= w_port_next;
            r_pcmsk <= w_pcmsk_next;
            r_pcif  <= w_pcif_next;
            case (r_state)
                ST_IDLE: begin
                    r_state <= w_accept ? ST_RESP : ST_IDLE;
                    r_ready <= w_accept;
                    r_wen   <= w_port_store;
                    r_rdata <= w_rdata;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_wen   <= 1'b0;
                    r_rdata <= 8'h00;
                end
            endcase
        end
    end

    assign bus_ready     = r_ready;
    assign bus_rdata     = r_rdata;
    assign port_write_en = r_wen;
    assign port_data     = r_port;
    assign ddr           = r_ddr;
    assign irq           = |r_pcif;

endmodule

`default_nettype wire
